// File: rtl/layernorm_stats_ctrl.sv
// layernorm_stats_ctrl
// Sequences one LayerNorm statistics request: start the mean unit, capture
// its result, start the variance unit with that mean held on mean_for_var,
// capture the variance, then pulse ln_done. A per-phase watchdog turns a unit
// that never answers into an error completion (ln_error=1) rather than a hang.
//
// Optional build macro: LNCTRL_PERF_CNT_EN adds perf_cycles, the number of
// cycles from request acceptance through ln_done for the latest request.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   ln_start            request, sampled only while idle
//   ln_busy, ln_done    busy level, one-cycle completion pulse
//   ln_error            status of the last completed request
//   mean_start/busy/valid/result   mean unit handshake and data
//   var_start/busy/valid/result    variance unit handshake and data
//   mean_for_var        captured mean, feeds the variance unit
//   mean_out, variance_out         results of the last successful request
//   perf_cycles         (LNCTRL_PERF_CNT_EN only) request cycle count
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for ln_start
// M_START | mean_start pulse, watchdog cleared
// M_WAIT  | waiting for mean_valid or watchdog expiry
// V_START | var_start pulse, mean_for_var already stable
// V_WAIT  | waiting for var_valid or watchdog expiry
// DONE    | ln_done pulse, back to IDLE
module layernorm_stats_ctrl #(
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ln_start,
  output logic                  ln_busy,
  output logic                  ln_done,
  output logic                  ln_error,
  output logic                  mean_start,
  input  logic                  mean_busy,
  input  logic                  mean_valid,
  input  logic [DATA_WIDTH-1:0] mean_result,
  output logic                  var_start,
  input  logic                  var_busy,
  input  logic                  var_valid,
  input  logic [DATA_WIDTH-1:0] var_result,
  output logic [DATA_WIDTH-1:0] mean_for_var,
  output logic [DATA_WIDTH-1:0] mean_out,
  output logic [DATA_WIDTH-1:0] variance_out
`ifdef LNCTRL_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_M_START = 3'd1;
  localparam logic [2:0] S_M_WAIT  = 3'd2;
  localparam logic [2:0] S_V_START = 3'd3;
  localparam logic [2:0] S_V_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state;
  logic [TO_W-1:0] watchdog;

  logic accept;
  logic wd_expired;
  logic mean_hit;
  logic var_hit;
  logic enter_done;

  // Busy flags from the units are informational only.
  logic unused_busy;
  assign unused_busy = mean_busy ^ var_busy;

  // Valid wins over an expiring watchdog on the same edge.
  always_comb begin
    accept     = (state == S_IDLE) && ln_start;
    wd_expired = (watchdog == WD_LAST);
    mean_hit   = (state == S_M_WAIT) && mean_valid;
    var_hit    = (state == S_V_WAIT) && var_valid;
    enter_done = ((state == S_M_WAIT) && !mean_valid && wd_expired) ||
                 ((state == S_V_WAIT) && (var_valid || wd_expired));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      watchdog     <= '0;
      ln_busy      <= 1'b0;
      ln_done      <= 1'b0;
      ln_error     <= 1'b0;
      mean_start   <= 1'b0;
      var_start    <= 1'b0;
      mean_for_var <= '0;
      mean_out     <= '0;
      variance_out <= '0;
    end else begin
      mean_start <= 1'b0;
      var_start  <= 1'b0;
      ln_done    <= enter_done;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_M_START;
            ln_busy    <= 1'b1;
            ln_error   <= 1'b0;
            mean_start <= 1'b1;
          end
        end
        S_M_START: begin
          state    <= S_M_WAIT;
          watchdog <= '0;
        end
        S_M_WAIT: begin
          if (mean_hit) begin
            mean_for_var <= mean_result;
            mean_out     <= mean_result;
            state        <= S_V_START;
            var_start    <= 1'b1;
          end else if (wd_expired) begin
            ln_error <= 1'b1;
            state    <= S_DONE;
          end else begin
            watchdog <= watchdog + TO_W'(1);
          end
        end
        S_V_START: begin
          state    <= S_V_WAIT;
          watchdog <= '0;
        end
        S_V_WAIT: begin
          if (var_hit) begin
            variance_out <= var_result;
            state        <= S_DONE;
          end else if (wd_expired) begin
            ln_error <= 1'b1;
            state    <= S_DONE;
          end else begin
            watchdog <= watchdog + TO_W'(1);
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          ln_busy <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          ln_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef LNCTRL_PERF_CNT_EN
  // run_cnt holds the number of request cycles up to and including the
  // current one, so the DONE cycle adds one more when it is published.
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] run_cnt;
  logic [31:0] run_next;

  assign run_next = (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept) begin
        run_cnt <= 32'd2;
      end else if ((state != S_IDLE) && (state != S_DONE)) begin
        run_cnt <= run_next;
      end
      if (enter_done) begin
        perf_cycles <= run_next;
      end
    end
  end
`endif

endmodule

// File: doc/layernorm_stats_ctrl.md
Name: layernorm_stats_ctrl

Overview:
- Initiator-side sequencer for the LayerNorm statistics path; drives the start/busy/valid handshake of the mean unit, then the variance unit.
- One request runs mean first. The captured mean is held on mean_for_var for the whole variance phase.
- Variance is then captured and completion is reported upstream.
- Watchdog per phase converts a hung unit into a clean error completion instead of a deadlock.

Parameters:
- DATA_WIDTH, 24, width of mean/variance results (matches variance unit).
- TIMEOUT_CYCLES, 256, max cycles waited for a unit's valid after its start pulse; legal range 2..65535.
- TO_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ln_start  in  1  request; sampled only in IDLE.
- ln_busy  out  1  high in every state except IDLE.
- ln_done  out  1  one-cycle completion pulse (success or error).
- ln_error  out  1  status of the last completed request; valid from ln_done onward.
- mean_start  out  1  one-cycle start pulse to mean unit.
- mean_busy  in  1  mean unit busy (monitored only, not required).
- mean_valid  in  1  mean result valid.
- mean_result  in  DATA_WIDTH  mean unit output.
- var_start  out  1  one-cycle start pulse to variance unit.
- var_busy  in  1  variance unit busy (monitored only).
- var_valid  in  1  variance result valid.
- var_result  in  DATA_WIDTH  variance unit output.
- mean_for_var  out  DATA_WIDTH  captured mean; drives variance unit mean_in.
- mean_out  out  DATA_WIDTH  registered mean of the last successful request.
- variance_out  out  DATA_WIDTH  registered variance of the last successful request.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; all outputs 0; watchdog 0. Reset mid-operation aborts immediately; no ln_done is issued.
- All outputs are registered. No combinational input-to-output paths.
- FSM states: IDLE, M_START, M_WAIT, V_START, V_WAIT, DONE.
- IDLE: if ln_start=1 at an edge, go to M_START and clear ln_error. Otherwise stay.
- M_START (1 cycle): mean_start=1. Load watchdog=0, go to M_WAIT.
- M_WAIT:
  - If mean_valid=1: mean_for_var<=mean_result and mean_out<=mean_result, then go to V_START.
  - Else if watchdog==TIMEOUT_CYCLES-1: ln_error<=1, go to DONE.
  - Else watchdog++.
- V_START (1 cycle): var_start=1, mean_for_var stable. Load watchdog=0, go to V_WAIT.
- V_WAIT:
  - If var_valid=1: variance_out<=var_result, go to DONE.
  - Else if watchdog==TIMEOUT_CYCLES-1: ln_error<=1, go to DONE.
  - Else watchdog++.
- DONE (1 cycle): ln_done=1, go to IDLE.
- Valid takes priority over timeout when both occur on the same edge.
- mean_valid/var_valid are ignored outside their own WAIT state, including a valid coincident with the start pulse and stray valids while IDLE.
- On timeout, mean_out/variance_out keep their prior values. mean_for_var keeps the last captured value.
- ln_start while ln_busy=1 is ignored; no queuing.
- ln_start high in the DONE cycle is ignored. It is accepted on the following IDLE edge if still high.
- Latency: for unit valid delays Dm and Dv (cycles after the start pulse, minimum 1), ln_done rises Dm+Dv+3 cycles after the ln_start edge.
  - Example: Dm=Dv=3 gives ln_done 9 cycles after ln_start is sampled.
- Timeout path: ln_done occurs exactly TIMEOUT_CYCLES cycles after the start pulse of the hung phase, plus 1.
- mean_busy/var_busy have no effect on control flow.

Optional Feature:
- Macro: LNCTRL_PERF_CNT_EN.
- With the macro: extra output port perf_cycles (32-bit).
  - Counts cycles from ln_start acceptance to ln_done inclusive for the most recent request.
  - Saturates at 0xFFFFFFFF; updated on ln_done; reset to 0.
- Without the macro: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst high 2 cycles.
  - Required: all outputs 0.
  - Required: stray mean_valid/var_valid pulses cause no state change, and ln_busy stays 0.
- Nominal: stub units with Dm=Dv=3, mean_result=100, var_result=0, ln_start pulsed.
  - Required: mean_start one cycle, then var_start with mean_for_var=100.
  - Required: ln_done 9 cycles after ln_start, mean_out=100, variance_out=0, ln_error=0.
  - Required (with LNCTRL_PERF_CNT_EN): perf_cycles=10.
- Mean hang: mean_valid never asserted, TIMEOUT_CYCLES=16.
  - Required: no var_start, ln_done with ln_error=1 at 17 cycles after mean_start.
  - Required: mean_out/variance_out unchanged.
- Back-to-back requests with ln_start held high.
  - Required: second request begins 1 cycle after the first ln_done.
  - Required: ln_error clears at the second acceptance.
  - Required: second results (mean 0x000200, var 0x000040) are captured.
- Busy rejection: ln_start pulsed in M_WAIT and in V_WAIT.
  - Required: no extra mean_start/var_start, single ln_done.
- Reset in V_WAIT, then var_valid after reset.
  - Required: no ln_done, outputs 0, IDLE; a new request completes normally.
